// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier slice.
//   mult_state_t  : controller states (IDLE, ADD, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand width; product/adder width is twice this
package mult_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADD   = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3
  } mult_state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/done handshake and operand/result bus between the lab top level
// (switches / hex display) and the multiplier.
//   Start, A, B              : driven by the requester (master)
//   Ready, Busy, Done, Product : driven by the multiplier (slave)
interface shift_add_multiplier_if #(
  parameter int WIDTH = 8
);

  logic                 Start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 Ready;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   Product;

  modport master (
    output Start, A, B,
    input  Ready, Busy, Done, Product
  );

  modport slave (
    input  Start, A, B,
    output Ready, Busy, Done, Product
  );

endinterface

// File: rtl/carry_lookahead_adder.sv
// WIDTH-bit adder built from per-bit generate/propagate terms and the
// lookahead carry recurrence. No carry-in; the carry out of the top bit
// is not produced because the multiplier never needs it.
//   a, b : addends
//   sum  : a + b mod 2^WIDTH
module carry_lookahead_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-2:0] g_s;
  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] c_s;

  // Generate/propagate terms and carries into every bit position.
  always_comb begin
    g_s    = a[WIDTH-2:0] & b[WIDTH-2:0];
    p_s    = a ^ b;
    c_s    = {WIDTH{1'b0}};
    c_s[0] = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      c_s[i] = g_s[i-1] | (p_s[i-1] & c_s[i-1]);
    end
  end

  assign sum = p_s ^ c_s;

endmodule

// File: rtl/mult_ctrl_fsm.sv
// Controller for the shift-and-add multiplier: state register, iteration
// counter and handshake outputs. Datapath registers live in the top.
//   clk, reset : clock, synchronous active-high reset
//   start      : request, honoured only in IDLE
//   load       : capture operands this edge (IDLE and start)
//   add_en     : conditional accumulate this edge (ADD)
//   shift_en   : shift M/Q this edge (SHIFT)
//   finish     : last SHIFT; product is captured this edge
//   ready, busy, done : registered handshake outputs
module mult_ctrl_fsm
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int ITERS = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic load,
  output logic add_en,
  output logic shift_en,
  output logic finish,
  output logic ready,
  output logic busy,
  output logic done
);

  // log2(WIDTH)+1 bits also covers the doubled iteration count of the signed build.
  localparam int                CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  mult_state_t       state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;

  // State, iteration count and handshake outputs, all updated together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= ADD;
            cnt_r   <= {CNT_W{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        ADD: begin
          state_r <= SHIFT;
        end
        SHIFT: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == CNT_LAST) begin
            state_r <= DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= ADD;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CNT_W{1'b0}};
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath strobes are decodes of the registered state so they align with the edge they act on.
  assign load     = (state_r == IDLE) && start;
  assign add_en   = (state_r == ADD);
  assign shift_en = (state_r == SHIFT);
  assign finish   = (state_r == SHIFT) && (cnt_r == CNT_LAST);

  assign ready = ready_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential WIDTH x WIDTH multiplier: one 2*WIDTH-bit adder reused every
// iteration (ADD then SHIFT per multiplier bit), start/done handshake.
//   Clk, Reset : clock, synchronous active-high reset
//   bus        : shift_add_multiplier_if.slave (Start, A, B in;
//                Ready, Busy, Done, Product out)
// Build option: SIGNED_MULT_EN -- when defined, A and B are two's complement,
// the multiplier register is sign-extended to 2*WIDTH and the loop runs
// 2*WIDTH iterations; Product is the signed product mod 2^(2*WIDTH).
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   Clk,
  input  logic                   Reset,
  shift_add_multiplier_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
`ifdef SIGNED_MULT_EN
  localparam int QW    = 2 * WIDTH;
  localparam int ITERS = 2 * WIDTH;
`else
  localparam int QW    = WIDTH;
  localparam int ITERS = WIDTH;
`endif

  logic [PW-1:0] p_r;
  logic [PW-1:0] m_r;
  logic [QW-1:0] q_r;
  logic [PW-1:0] product_r;
  logic [PW-1:0] sum_s;

  logic load_s;
  logic add_en_s;
  logic shift_en_s;
  logic finish_s;
  logic ready_s;
  logic busy_s;
  logic done_s;

  mult_ctrl_fsm #(
    .WIDTH (WIDTH),
    .ITERS (ITERS)
  ) u_ctrl (
    .clk      (Clk),
    .reset    (Reset),
    .start    (bus.Start),
    .load     (load_s),
    .add_en   (add_en_s),
    .shift_en (shift_en_s),
    .finish   (finish_s),
    .ready    (ready_s),
    .busy     (busy_s),
    .done     (done_s)
  );

  // Only shared adder; its carry out is irrelevant because the product fits in PW bits.
  carry_lookahead_adder #(
    .WIDTH (PW)
  ) u_adder (
    .a   (p_r),
    .b   (m_r),
    .sum (sum_s)
  );

  // Accumulator, shifting multiplicand/multiplier and the held result.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      p_r       <= {PW{1'b0}};
      m_r       <= {PW{1'b0}};
      q_r       <= {QW{1'b0}};
      product_r <= {PW{1'b0}};
    end else if (load_s) begin
      p_r <= {PW{1'b0}};
`ifdef SIGNED_MULT_EN
      m_r <= {{WIDTH{bus.A[WIDTH-1]}}, bus.A};
      q_r <= {{WIDTH{bus.B[WIDTH-1]}}, bus.B};
`else
      m_r <= {{WIDTH{1'b0}}, bus.A};
      q_r <= bus.B;
`endif
    end else if (add_en_s) begin
      if (q_r[0]) begin
        p_r <= sum_s;
      end else begin
        p_r <= p_r;
      end
    end else if (shift_en_s) begin
      m_r <= m_r << 1;
      q_r <= q_r >> 1;
      // P is final after the last ADD, so capture it as DONE is entered.
      if (finish_s) begin
        product_r <= p_r;
      end else begin
        product_r <= product_r;
      end
    end else begin
      p_r <= p_r;
    end
  end

  assign bus.Ready   = ready_s;
  assign bus.Busy    = busy_s;
  assign bus.Done    = done_s;
  assign bus.Product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Randomised scoreboard bench for shift_add_multiplier. The driver pushes the
// expected product and Done cycle for every accepted request; a monitor pops
// and compares whenever Done is seen. Honours SIGNED_MULT_EN like the design.
module tb_shift_add_multiplier;

  localparam int W  = 8;
  localparam int PW = 2 * W;
`ifdef SIGNED_MULT_EN
  localparam int ITERS = 2 * W;
`else
  localparam int ITERS = W;
`endif

  typedef struct {
    logic [PW-1:0] exp_prod;
    int            exp_cyc;
  } exp_t;

  logic clk;
  logic Reset;
  int   cyc;
  int   checks;
  int   errors;
  int   next_free;
  exp_t exp_q[$];

  shift_add_multiplier_if #(.WIDTH(W)) bus ();

  shift_add_multiplier #(.WIDTH(W)) dut (
    .Clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer multiplication reduced to the product width.
  function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SIGNED_MULT_EN
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    return PW'(sa * sb);
`else
    int ua;
    int ub;
    ua = int'(a);
    ub = int'(b);
    return PW'(ua * ub);
`endif
  endfunction

  // Monitor: every Done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.Done === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("product", 32'(bus.Product), 32'(e.exp_prod));
        check("done_cycle", 32'(cyc), 32'(e.exp_cyc));
      end
    end
  end

  task automatic wait_free();
    while (cyc < next_free) @(negedge clk);
  endtask

  // Issue one request at a negedge; accepted at the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    wait_free();
    bus.A     = a;
    bus.B     = b;
    bus.Start = 1'b1;
    e.exp_prod = model(a, b);
    e.exp_cyc  = cyc + 1 + 2 * ITERS;
    exp_q.push_back(e);
    next_free = cyc + 2 + 2 * ITERS;
    @(negedge clk);
    bus.Start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    check("busy_after_accept", 32'(bus.Busy), 32'd1);
    check("ready_after_accept", 32'(bus.Ready), 32'd0);
  endtask

  task automatic run_and_idle(input logic [W-1:0] a, input logic [W-1:0] b);
    issue(a, b);
    wait_free();
    check("ready_after_done", 32'(bus.Ready), 32'd1);
    check("busy_after_done", 32'(bus.Busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int k;
    exp_t e;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    next_free = 0;
    Reset     = 1'b1;
    bus.Start = 1'b0;
    bus.A     = {W{1'b0}};
    bus.B     = {W{1'b0}};
    repeat (3) @(negedge clk);
    Reset = 1'b0;
    check("reset_ready", 32'(bus.Ready), 32'd1);
    check("reset_busy", 32'(bus.Busy), 32'd0);
    check("reset_done", 32'(bus.Done), 32'd0);
    check("reset_product", 32'(bus.Product), 32'd0);
    next_free = cyc;

    // Directed values from the specification.
    run_and_idle(8'h0F, 8'h0F);
    run_and_idle(8'hFF, 8'hFF);
    run_and_idle(8'h00, 8'hAB);
    run_and_idle(8'hFF, 8'h02);
    run_and_idle(8'h80, 8'h80);
    run_and_idle(8'h7F, 8'h81);

    // Start pulse while busy must be ignored.
    issue(8'h03, 8'h05);
    repeat (3) @(negedge clk);
    check("ready_while_busy", 32'(bus.Ready), 32'd0);
    bus.A     = 8'h10;
    bus.B     = 8'h10;
    bus.Start = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0;
    wait_free();

    // Start held high: two back-to-back runs, no gap beyond the DONE/IDLE cycles.
    k         = cyc;
    bus.A     = 8'h02;
    bus.B     = 8'h03;
    bus.Start = 1'b1;
    e.exp_prod = model(8'h02, 8'h03);
    e.exp_cyc  = k + 1 + 2 * ITERS;
    exp_q.push_back(e);
    e.exp_cyc  = k + 3 + 4 * ITERS;
    exp_q.push_back(e);
    while (cyc < k + 2 + 2 * ITERS) @(negedge clk);
    @(negedge clk);
    bus.Start = 1'b0;
    next_free = k + 4 + 4 * ITERS;
    wait_free();

    // Reset in the middle of a run: no result, no Done.
    issue(8'hC3, 8'h5A);
    repeat (7) @(negedge clk);
    Reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    Reset = 1'b0;
    check("midreset_ready", 32'(bus.Ready), 32'd1);
    check("midreset_busy", 32'(bus.Busy), 32'd0);
    check("midreset_done", 32'(bus.Done), 32'd0);
    check("midreset_product", 32'(bus.Product), 32'd0);
    next_free = cyc;
    repeat (2 * ITERS + 4) @(negedge clk);

    // Randomised runs with random idle gaps and occasional corner operands.
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = (i % 6 == 0) ? 8'hFF : W'($urandom);
      rb = (i % 7 == 3) ? 8'h00 : W'($urandom);
      wait_free();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(ra, rb);
    end

    wait_free();
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
